// File: rtl/clk_divider_if.sv
// Run-control and status bundle for the programmable clock divider.
// master drives enable/div_value/load; slave returns clk_out/tick/status.
interface clk_divider_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] div_value;
    logic             load;
    logic             clk_out;
    logic             tick;
    logic             running;
    logic             update_pending;

    modport master (
        output enable,
        output div_value,
        output load,
        input  clk_out,
        input  tick,
        input  running,
        input  update_pending
    );

    modport slave (
        input  enable,
        input  div_value,
        input  load,
        output clk_out,
        output tick,
        output running,
        output update_pending
    );
endinterface

// File: rtl/clk_divider.sv
// Glitch-free programmable divider: 50% duty clk_out plus a one-cycle
// tick per period; divisor updates take effect only at period starts.
// Ports: clk, rst_n (async, active-low), bus (clk_divider_if.slave):
//   enable, div_value, load in; clk_out, tick, running, update_pending out.
module clk_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 0
) (
    input logic          clk,
    input logic          rst_n,
    clk_divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_reg;
    logic [WIDTH-1:0] pend;
    logic             pend_vld;
    logic             clk_q;
    logic             tick_q;
    logic             run_q;

    logic             hit;
    logic [WIDTH-1:0] next_div;

    // Phase ends when cnt reaches div_reg; this fires before cnt can wrap,
    // so div_reg = all-ones still yields a full 2^WIDTH-cycle phase.
    assign hit = (cnt == div_reg);

    // Divisor chosen at a boundary: a same-cycle load beats a pending one.
    always_comb begin
        next_div = div_reg;
        if (bus.load) begin
            next_div = bus.div_value;
        end else if (pend_vld) begin
            next_div = pend;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            div_reg  <= WIDTH'(DEFAULT_DIV);
            pend     <= '0;
            pend_vld <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state    <= HIGH;
                        clk_q    <= 1'b1;
                        tick_q   <= 1'b1;
                        run_q    <= 1'b1;
                        cnt      <= '0;
                        div_reg  <= next_div;
                        pend_vld <= 1'b0;
                    end else if (bus.load) begin
                        // Nothing is running, so write straight through;
                        // this also supersedes any older pending value.
                        div_reg  <= bus.div_value;
                        pend_vld <= 1'b0;
                    end
                end
                HIGH: begin
                    if (hit) begin
                        state <= LOW;
                        clk_q <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                    if (bus.load) begin
                        pend     <= bus.div_value;
                        pend_vld <= 1'b1;
                    end
                end
                LOW: begin
                    if (hit && bus.enable) begin
                        state    <= HIGH;
                        clk_q    <= 1'b1;
                        tick_q   <= 1'b1;
                        cnt      <= '0;
                        div_reg  <= next_div;
                        pend_vld <= 1'b0;
                    end else begin
                        if (hit) begin
                            state <= IDLE;
                            run_q <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + WIDTH'(1);
                        end
                        if (bus.load) begin
                            pend     <= bus.div_value;
                            pend_vld <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    clk_q <= 1'b0;
                    run_q <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.clk_out        = clk_q;
    assign bus.tick           = tick_q;
    assign bus.running        = run_q;
    assign bus.update_pending = pend_vld;

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider: directed scenarios plus random
// enable/load traffic compared against a period-position reference model.
module tb_clk_divider;

    localparam int W   = 4;
    localparam int DEF = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    clk_divider_if #(.WIDTH(W)) bus ();

    clk_divider #(
        .WIDTH      (W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a period is 2H cycles; position 0..H-1 is high.
    bit m_in;
    int m_pos;
    int m_h;
    int m_div;
    bit m_pv;
    int m_pval;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in   = 1'b0;
        m_pos  = 0;
        m_h    = 1;
        m_div  = DEF;
        m_pv   = 1'b0;
        m_pval = 0;
    endtask

    task automatic model_edge(bit en, bit ld, int dv);
        bit was_in;
        bit start;
        int d;
        was_in = m_in;
        start  = 1'b0;
        if (m_in) begin
            if (m_pos == 2 * m_h - 1) begin
                start = en;
                if (!en) m_in = 1'b0;
            end else begin
                m_pos++;
            end
        end else begin
            start = en;
        end
        if (start) begin
            d     = ld ? dv : (m_pv ? m_pval : m_div);
            m_div = d;
            m_pv  = 1'b0;
            m_h   = d + 1;
            m_pos = 0;
            m_in  = 1'b1;
        end else if (ld) begin
            if (!was_in) begin
                m_div = dv;
                m_pv  = 1'b0;
            end else begin
                m_pval = dv;
                m_pv   = 1'b1;
            end
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".clk_out"}, 32'(bus.clk_out),
            32'(m_in && (m_pos < m_h)));
        chk({tag, ".tick"}, 32'(bus.tick), 32'(m_in && (m_pos == 0)));
        chk({tag, ".running"}, 32'(bus.running), 32'(m_in));
        chk({tag, ".pending"}, 32'(bus.update_pending), 32'(m_pv));
    endtask

    task automatic cyc(string tag, bit en, bit ld, int dv);
        bus.enable    = en;
        bus.load      = ld;
        bus.div_value = dv[W-1:0];
        @(posedge clk);
        model_edge(en, ld, dv);
        #1;
        check_all(tag);
        bus.load = 1'b0;
    endtask

    // Called 1 time unit after a rising edge: reset lands mid-cycle.
    task automatic async_reset(string tag);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2 rst_n = 1'b1;
    endtask

    int highs;
    int ticks;

    initial begin
        bus.enable    = 1'b0;
        bus.load      = 1'b0;
        bus.div_value = '0;
        model_reset();
        #2;
        check_all("reset");
        rst_n = 1'b1;

        // clk/2 from reset
        for (int i = 0; i < 8; i++) cyc("t1", 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) cyc("t1off", 1'b0, 1'b0, 0);
        chk("t1.idle", 32'(bus.running), 32'd0);

        // direct load in idle, H=4
        cyc("t2ld", 1'b0, 1'b1, 3);
        highs = 0;
        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            cyc("t2", 1'b1, 1'b0, 0);
            highs += int'(bus.clk_out);
            ticks += int'(bus.tick);
        end
        chk("t2.highs", 32'(highs), 32'd8);
        chk("t2.ticks", 32'(ticks), 32'd2);

        // pending loads, last wins
        cyc("t3", 1'b1, 1'b0, 0);
        cyc("t3ldh", 1'b1, 1'b1, 1);
        chk("t3.pend", 32'(bus.update_pending), 32'd1);
        for (int i = 0; i < 3; i++) cyc("t3", 1'b1, 1'b0, 0);
        cyc("t3ldl", 1'b1, 1'b1, 2);
        for (int i = 0; i < 14; i++) cyc("t3", 1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) cyc("t3off", 1'b0, 1'b0, 0);

        // drop enable in first HIGH cycle, H=2
        cyc("t4ld", 1'b0, 1'b1, 1);
        cyc("t4", 1'b1, 1'b0, 0);
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            cyc("t4", 1'b0, 1'b0, 0);
            ticks += int'(bus.tick);
        end
        chk("t4.ticks", 32'(ticks), 32'd0);
        chk("t4.clk_out", 32'(bus.clk_out), 32'd0);

        // async reset mid-HIGH, H=5
        cyc("t5ld", 1'b0, 1'b1, 4);
        for (int i = 0; i < 3; i++) cyc("t5", 1'b1, 1'b0, 0);
        async_reset("t5rst");
        for (int i = 0; i < 6; i++) cyc("t5post", 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) cyc("t5off", 1'b0, 1'b0, 0);

        // max divisor, H=16
        cyc("t6ld", 1'b0, 1'b1, 15);
        highs = 0;
        ticks = 0;
        for (int i = 0; i < 64; i++) begin
            cyc("t6", 1'b1, 1'b0, 0);
            highs += int'(bus.clk_out);
            ticks += int'(bus.tick);
        end
        chk("t6.highs", 32'(highs), 32'd32);
        chk("t6.ticks", 32'(ticks), 32'd2);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit en;
            bit ld;
            int dv;
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 11) == 0);
            dv = int'($urandom_range(0, 15));
            if ((i / 200) % 3 == 2) dv = int'($urandom_range(0, 2));
            cyc("rnd", en, ld, dv);
            if ($urandom_range(0, 399) == 0) async_reset("rndrst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
